// File: rtl/cnt_chk_pkg.sv
// Shared types and defaults for the counter-stream checker.
// Optional build macro: CNT_CHK_HOLD_EN (stalled counter is a legal hold).
package cnt_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam int CNT_W_DEF  = 6;
    localparam int ERR_W_DEF  = 8;
    localparam int LOCK_N_DEF = 4;

endpackage

// File: rtl/cnt_chk_sat_ctr.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module cnt_chk_sat_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cnt_seq_checker.sv
// Monitor for a free-running wrap-around counter stream.
// Optional build macro: CNT_CHK_HOLD_EN (repeated value is a legal hold).
module cnt_seq_checker
    import cnt_chk_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int ERR_W  = ERR_W_DEF,
    parameter int LOCK_N = LOCK_N_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [CNT_W-1:0] in_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             cap_vld,
    output logic [CNT_W-1:0] cap_exp,
    output logic [CNT_W-1:0] cap_got
);

    localparam logic [CNT_W-1:0] ONE    = 1;
    localparam logic [3:0]       LOCK_V = LOCK_N[3:0];

    state_t           state;
    logic [CNT_W-1:0] prev;
    logic [CNT_W-1:0] exp_v;
    logic [3:0]       run;
    logic [3:0]       run_nx;
    logic             take;
    logic             match;
    logic             hold;
    logic             bad;

    assign exp_v  = prev + ONE;
    assign run_nx = run + 4'd1;
    assign take   = in_vld && !clr;
    assign match  = (in_cnt == exp_v);

`ifdef CNT_CHK_HOLD_EN
    assign hold = (in_cnt == prev);
`else
    assign hold = 1'b0;
`endif

    assign bad = take && (state == LOCK) && !match && !hold;

    cnt_chk_sat_ctr #(
        .W(ERR_W)
    ) u_err_ctr (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .inc  (bad),
        .cnt  (err_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            cap_vld   <= 1'b0;
            cap_exp   <= '0;
            cap_got   <= '0;
            prev      <= '0;
            run       <= '0;
        end else if (clr) begin
            state     <= IDLE;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            cap_vld   <= 1'b0;
            cap_exp   <= '0;
            cap_got   <= '0;
            run       <= '0;
        end else begin
            err_pulse <= bad;
            if (take) begin
                prev <= in_cnt;
                unique case (state)
                    IDLE: begin
                        state <= ACQ;
                        run   <= '0;
                    end
                    ACQ: begin
                        if (match) begin
                            run <= run_nx;
                            if (run_nx == LOCK_V) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                            end
                        end else if (!hold) begin
                            run <= '0;
                        end
                    end
                    LOCK: begin
                        if (!match && !hold) begin
                            state  <= ACQ;
                            locked <= 1'b0;
                            run    <= '0;
                            // only the first mismatch is kept for debug
                            if (!cap_vld) begin
                                cap_vld <= 1'b1;
                                cap_exp <= exp_v;
                                cap_got <= in_cnt;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                        run    <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/cnt_seq_checker.md
Name: cnt_seq_checker

Overview:
- Receive-side checker for the free-running wrap-around counter stream used by the NPC simulation benches.
- Samples an incoming counter value on each valid cycle and acquires lock after LOCK_N consecutive +1 steps.
- Once locked, flags and counts every sample that is not previous+1 modulo 2^CNT_W, and captures the first mismatch for debug.
- Sits beside any counter source (DUT or bench) as a self-checking monitor, so benches need no waveform inspection.

Parameters:
- CNT_W, 6, width of the observed counter.
- ERR_W, 8, width of the error counter; saturates at all-ones.
- LOCK_N, 4, consecutive correct steps needed to enter LOCK; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rstn  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear: returns to IDLE, zeroes err_cnt, clears capture; overrides in_vld in the same cycle.
- in_vld  input  1  in_cnt is valid this cycle.
- in_cnt  input  CNT_W  observed counter value.
- locked  output  1  high while in LOCK.
- err_pulse  output  1  one-cycle pulse, the cycle after a bad sample is taken in LOCK.
- err_cnt  output  ERR_W  number of errors seen in LOCK; saturating.
- cap_vld  output  1  sticky; high once the first mismatch has been captured.
- cap_exp  output  CNT_W  expected value at the first mismatch.
- cap_got  output  CNT_W  received value at the first mismatch.

Behaviour:
- Reset (async, rstn=0), values held until the first valid sample after release:
  - state=IDLE, locked=0, err_pulse=0, err_cnt=0, cap_vld=0, cap_exp=0, cap_got=0.
  - Internal prev=0 and run=0.
- Internal registers:
  - prev[CNT_W]: last accepted sample.
  - run[4]: consecutive good-step count.
  - exp = prev+1, truncated to CNT_W, so all-ones wraps to 0.
- A sample is taken only on a posedge with in_vld=1 and clr=0. Cycles with in_vld=0 change nothing except err_pulse, which returns to 0.
- State transitions (every taken sample sets prev <= in_cnt):
  - IDLE: on a sample -> ACQ, run=0.
  - ACQ, in_cnt==exp: run+1. When run+1==LOCK_N -> LOCK (locked=1 on the next cycle).
  - ACQ, in_cnt!=exp: run=0, stay in ACQ (resync on the new value). No error is reported.
  - LOCK, in_cnt==exp: stay in LOCK.
  - LOCK, in_cnt!=exp: err_pulse=1 for the next cycle only; err_cnt increments unless already all-ones; -> ACQ with run=0 and locked=0.
  - LOCK mismatch with cap_vld=0: cap_exp<=exp, cap_got<=in_cnt, cap_vld<=1. Later mismatches never overwrite the capture.
- Latency: every output is registered and reflects the sample taken on the preceding posedge.
- Back-to-back errors are impossible: the first error forces ACQ, and ACQ never reports.
- clr mid-lock: the next cycle has state=IDLE, locked=0, err_cnt=0, cap_vld=0, err_pulse=0.
- Reset asserted mid-operation: immediate return to all reset values, independent of clk.
- Wrap-around: prev = 2^CNT_W-1 followed by in_cnt=0 is a correct step.

Optional Feature:
- Macro: CNT_CHK_HOLD_EN.
- Defined: in LOCK, in_cnt==prev (counter stalled) is a legal hold. No error, state unchanged. In ACQ a hold leaves run unchanged.
- Undefined: a repeated value is a mismatch like any other (error in LOCK, resync in ACQ).

Decomposition:
- Shared package cnt_chk_pkg holds:
  - state enum {IDLE, ACQ, LOCK} as a 2-bit typedef.
  - Default constants CNT_W_DEF=6, ERR_W_DEF=8, LOCK_N_DEF=4.
- One natural sub-module: cnt_chk_sat_ctr, a parameterised saturating incrementer with sync clear, used for err_cnt.
- Compare, step logic and FSM stay in the top module.

Test Plan:
- Reset, then feed in_vld=1 with in_cnt 0,1,2,3,4 on consecutive cycles -> locked=1 the cycle after the sample 4 (LOCK_N=4); err_cnt=0.
- Locked at 9, then feed 10,13 -> err_pulse=1 for exactly one cycle, err_cnt=1, cap_exp=11, cap_got=13, cap_vld=1, locked=0. Then feed 14..18 -> relocks, capture unchanged.
- Locked, feed 62,63,0,1 (CNT_W=6) -> no error, locked stays 1 through the wrap.
- Locked, in_vld low for 7 cycles, then the next value in sequence -> no error; outputs unchanged during the gap.
- Drive 300 forced errors, each followed by a 4-step relock -> err_cnt saturates at 255 and does not wrap. Then clr=1 together with in_vld=1 -> the next cycle has err_cnt=0, cap_vld=0, state IDLE.
- With CNT_CHK_HOLD_EN defined, locked, feed 20,20,21 -> no error, stays locked. Without the macro, the same stimulus gives err_pulse=1, cap_exp=21, cap_got=20. Asserting rstn=0 mid-stream clears all outputs asynchronously.
